instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32IM instruction encoder: the inverse of the core's `decoder`. It accepts decoded micro-op fields over a valid/ready handshake, packs each one into a 32-bit instruction word, range-checks the immediate, and writes the word into instruction memory at consecutive word addresses. It sits between the test/boot program generator and the IMEM write port. The core's own decode path is not involved.

## Interface
Parameters:
- `ADDR_W`, default 12. Width of the IMEM word address.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; loads `base_addr`, clears `count`/`err`, enters RUN. Only accepted in IDLE or ERR.
- `base_addr`  in  ADDR_W  first word address.
- `in_valid` / `in_ready`  in / out  1  handshake. A transfer occurs when both are high on a rising edge.
- `in_alucode`  in  6  ALU_* code from `define.vh`.
- `in_aluop1_type`, `in_aluop2_type`  in  2  OP_TYPE_* codes.
- `in_rs1`, `in_rs2`, `in_rd`  in  5  register numbers.
- `in_imm`  in  32  immediate in the form the decoder produces (sign-extended, byte offsets, LUI/AUIPC pre-shifted).
- `in_last`  in  1  marks the final word of the program.
- `imem_we`  out  1  IMEM write strobe.
- `imem_addr`  out  ADDR_W  IMEM write address.
- `imem_wdata`  out  32  encoded instruction word.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse when the last word has been written.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  error cause: 0 none, 1 ILLEGAL, 2 RANGE, 3 OVERFLOW.
- `count`  out  ADDR_W+1  number of words written since `start`.

Reset value of every output is 0.

## Operation
- States and transitions:
  - IDLE: `start` → RUN.
  - RUN: accepting `in_last` → DRAIN; detecting an error → ERR.
  - DRAIN: pipeline empty → pulse `done`, go to IDLE; detecting an error → ERR.
  - ERR: `start` → RUN.
- `in_ready = (state==RUN) && !err`.
- Opcode selection:
  - ALU_ADD with op1 IMM and op2 PC → AUIPC.
  - Arithmetic/logic alucode with op2 IMM → OP-IMM; with op2 REG → OP.
  - ALU_LUI → LUI; ALU_JAL → JAL; ALU_JALR → JALR.
  - ALU_B* → BRANCH; ALU_S* → STORE; ALU_L* → LOAD.
- funct3/funct7 are the inverse of the decoder's mapping. Specifically: SUB and SRA set `ir[30]`; M-extension codes set `ir[25]`.
- Immediate packing follows the I/S/B/U/J layouts. Shift immediates occupy `ir[24:20]`.
- Range checks (failure → RANGE):
  - I and S types: −2048..2047.
  - Shift amount: 0..31.
  - B type: even, −4096..4094.
  - J type: even, ±1 MiB.
  - U type: `imm[11:0]==0`.
- Any alucode or type combination with no encoding → ILLEGAL.
- A word that fails a check is not written. The encoder sets `err` and `err_code` and enters ERR; the word in stage 1 is discarded.
- Address wrap: writing when `imem_addr` would pass 2^ADDR_W−1 → OVERFLOW. The address never wraps silently.
- `start` in RUN or DRAIN is ignored.
- Reset mid-operation clears all state. Words already written remain in IMEM.

## Timing
- Two-stage pipeline:
  - A word accepted at edge N is registered in S1.
  - It is encoded and checked into S2 at N+1.
  - `imem_we`/`imem_addr`/`imem_wdata` are valid in the cycle after N+1.
- Latency from acceptance to the write strobe: 2 cycles.
- Throughput: 1 word per cycle. IMEM never back-pressures.
- `err` rises in the same cycle in which the bad word's strobe would have occurred. `in_ready` falls in that same cycle.
- `done` pulses the cycle after the strobe of the last word.
- `count` increments with each strobe.

## Configuration
- Macro `ENCODER_MEXT_EN`.
  - Defined: ALU_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU are encoded with funct7=0000001.
  - Undefined: those codes report ILLEGAL and no M-extension logic is instantiated.

## Structure
- Shared package:
  - Opcode constants (OPIMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, STORE, LOAD).
  - `err_code` enumeration.
  - FSM state enumeration.
- ALU_* and OP_TYPE_* definitions stay in `define.vh`.
- One sub-module, `rv_encode_word`: purely combinational fields → {word, illegal, range_err}. It is used by S2.

## Test plan
- `start`, `base_addr`=0x010; ADDI x1,x0,5 (ALU_ADD, op1 REG, op2 IMM, imm 5, last) → after 2 cycles write 0x00500093 @0x010; `done` the next cycle; `count`=1.
- Back-to-back words SUB x3,x1,x2, then LUI x5 with imm 0x12345000 → 0x402081B3 @base, then 0x123452B7 @base+1, in consecutive cycles.
- BEQ with imm=3 → no write; `err`=1, `err_code`=2; `in_ready`=0. A following `start` clears the error and restarts.
- `ADDR_W`=4, `base_addr`=0xE, three words → writes @0xE and @0xF; the third word raises OVERFLOW (`err_code`=3) and is not written.
- `ENCODER_MEXT_EN` defined, MUL x1,x2,x3 → 0x023100B3. Macro undefined → ILLEGAL (`err_code`=1), no write.
- Assert `rst` while in DRAIN with two words in flight → all outputs are 0 on the next edge, with no `done` and no further writes.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared definitions for the RV32IM instruction encoder:
//                ALU operation and operand-type codes shared with the core's
//                decoder, RV32 base opcodes, the error-code and FSM state
//                enumerations, and the internal immediate-format selector.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

   // ALU operation codes produced by the decoder
   localparam logic [5:0] ALU_ADD    = 6'd0;
   localparam logic [5:0] ALU_SUB    = 6'd1;
   localparam logic [5:0] ALU_SLL    = 6'd2;
   localparam logic [5:0] ALU_SLT    = 6'd3;
   localparam logic [5:0] ALU_SLTU   = 6'd4;
   localparam logic [5:0] ALU_XOR    = 6'd5;
   localparam logic [5:0] ALU_SRL    = 6'd6;
   localparam logic [5:0] ALU_SRA    = 6'd7;
   localparam logic [5:0] ALU_OR     = 6'd8;
   localparam logic [5:0] ALU_AND    = 6'd9;
   localparam logic [5:0] ALU_BEQ    = 6'd10;
   localparam logic [5:0] ALU_BNE    = 6'd11;
   localparam logic [5:0] ALU_BLT    = 6'd12;
   localparam logic [5:0] ALU_BGE    = 6'd13;
   localparam logic [5:0] ALU_BLTU   = 6'd14;
   localparam logic [5:0] ALU_BGEU   = 6'd15;
   localparam logic [5:0] ALU_LB     = 6'd16;
   localparam logic [5:0] ALU_LH     = 6'd17;
   localparam logic [5:0] ALU_LW     = 6'd18;
   localparam logic [5:0] ALU_LBU    = 6'd19;
   localparam logic [5:0] ALU_LHU    = 6'd20;
   localparam logic [5:0] ALU_SB     = 6'd21;
   localparam logic [5:0] ALU_SH     = 6'd22;
   localparam logic [5:0] ALU_SW     = 6'd23;
   localparam logic [5:0] ALU_JAL    = 6'd24;
   localparam logic [5:0] ALU_JALR   = 6'd25;
   localparam logic [5:0] ALU_LUI    = 6'd26;
   // M-extension block: low three bits equal the R-type funct3
   localparam logic [5:0] ALU_MUL    = 6'd32;
   localparam logic [5:0] ALU_MULH   = 6'd33;
   localparam logic [5:0] ALU_MULHSU = 6'd34;
   localparam logic [5:0] ALU_MULHU  = 6'd35;
   localparam logic [5:0] ALU_DIV    = 6'd36;
   localparam logic [5:0] ALU_DIVU   = 6'd37;
   localparam logic [5:0] ALU_REM    = 6'd38;
   localparam logic [5:0] ALU_REMU   = 6'd39;
   localparam logic [5:0] ALU_NOP    = 6'd63;

   // Operand source types
   localparam logic [1:0] OP_TYPE_NONE = 2'd0;
   localparam logic [1:0] OP_TYPE_REG  = 2'd1;
   localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
   localparam logic [1:0] OP_TYPE_PC   = 2'd3;

   // RV32 major opcodes
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ILLEGAL  = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_OVERFLOW = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   // Instruction layout; FMT_SH is I-type with funct7 above a 5-bit shamt
   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_SH = 3'd2,
      FMT_S  = 3'd3,
      FMT_B  = 3'd4,
      FMT_U  = 3'd5,
      FMT_J  = 3'd6
   } fmt_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_encode.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv_encode_word
//  Description : Combinational packer: decoded micro-op fields ->
//                {32-bit instruction word, illegal flag, range-error flag}.
//                M-extension codes are encoded only when ENCODER_MEXT_EN is
//                defined; otherwise they are reported illegal.
//  Ports       : i_alucode, i_op1_type, i_op2_type, i_rs1, i_rs2, i_rd, i_imm
//                -> o_word, o_illegal, o_range_err
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_encode_word (
   input  logic [5:0]  i_alucode,
   input  logic [1:0]  i_op1_type,
   input  logic [1:0]  i_op2_type,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_illegal,
   output logic        o_range_err
);
   import instr_encoder_pkg::*;

   fmt_t        w_fmt;
   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic        w_illegal;
   logic        w_arith;
   logic        w_shift;
   logic        w_op1_reg;
   logic        w_op2_reg;
   logic        w_op2_imm;
   // Signed-fit tests: all bits above the sign bit must equal the sign bit
   logic        w_fit12;
   logic        w_fit13;
   logic        w_fit21;

   assign w_op1_reg = (i_op1_type == OP_TYPE_REG);
   assign w_op2_reg = (i_op2_type == OP_TYPE_REG);
   assign w_op2_imm = (i_op2_type == OP_TYPE_IMM);
   // ADD..AND are contiguous codes
   assign w_arith   = (i_alucode <= ALU_AND);
   assign w_shift   = (i_alucode == ALU_SLL) || (i_alucode == ALU_SRL) ||
                      (i_alucode == ALU_SRA);
   assign w_fit12   = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign w_fit13   = (&i_imm[31:12]) | ~(|i_imm[31:12]);
   assign w_fit21   = (&i_imm[31:20]) | ~(|i_imm[31:20]);

   // Field selection
   always_comb begin
      w_fmt     = FMT_R;
      w_opc     = OPC_OP;
      w_f3      = 3'b000;
      w_f7      = 7'b0000000;
      w_illegal = 1'b0;

      case (i_alucode)
         ALU_SUB:  w_f7 = 7'b0100000;
         ALU_SLL:  w_f3 = 3'b001;
         ALU_SLT:  w_f3 = 3'b010;
         ALU_SLTU: w_f3 = 3'b011;
         ALU_XOR:  w_f3 = 3'b100;
         ALU_SRL:  w_f3 = 3'b101;
         ALU_SRA:  begin w_f3 = 3'b101; w_f7 = 7'b0100000; end
         ALU_OR:   w_f3 = 3'b110;
         ALU_AND:  w_f3 = 3'b111;
         ALU_BNE:  w_f3 = 3'b001;
         ALU_BLT:  w_f3 = 3'b100;
         ALU_BGE:  w_f3 = 3'b101;
         ALU_BLTU: w_f3 = 3'b110;
         ALU_BGEU: w_f3 = 3'b111;
         ALU_LH:   w_f3 = 3'b001;
         ALU_LW:   w_f3 = 3'b010;
         ALU_LBU:  w_f3 = 3'b100;
         ALU_LHU:  w_f3 = 3'b101;
         ALU_SH:   w_f3 = 3'b001;
         ALU_SW:   w_f3 = 3'b010;
         default:  w_f3 = 3'b000;
      endcase

      if (w_arith) begin
         if ((i_alucode == ALU_ADD) && (i_op1_type == OP_TYPE_IMM) &&
             (i_op2_type == OP_TYPE_PC)) begin
            w_opc = OPC_AUIPC;
            w_fmt = FMT_U;
         end else if (w_op1_reg && w_op2_reg) begin
            w_opc = OPC_OP;
            w_fmt = FMT_R;
         end else if (w_op1_reg && w_op2_imm && (i_alucode != ALU_SUB)) begin
            w_opc = OPC_OPIMM;
            w_fmt = w_shift ? FMT_SH : FMT_I;
         end else begin
            w_illegal = 1'b1;
         end
      end else begin
         case (i_alucode)
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
               w_opc = OPC_BRANCH;
               w_fmt = FMT_B;
            end
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU: begin
               w_opc = OPC_LOAD;
               w_fmt = FMT_I;
            end
            ALU_SB, ALU_SH, ALU_SW: begin
               w_opc = OPC_STORE;
               w_fmt = FMT_S;
            end
            ALU_JAL: begin
               w_opc = OPC_JAL;
               w_fmt = FMT_J;
            end
            ALU_JALR: begin
               w_opc = OPC_JALR;
               w_fmt = FMT_I;
            end
            ALU_LUI: begin
               w_opc = OPC_LUI;
               w_fmt = FMT_U;
            end
`ifdef ENCODER_MEXT_EN
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
               if (w_op1_reg && w_op2_reg) begin
                  w_opc = OPC_OP;
                  w_fmt = FMT_R;
                  w_f3  = i_alucode[2:0];
                  w_f7  = 7'b0000001;
               end else begin
                  w_illegal = 1'b1;
               end
            end
`endif
            default: w_illegal = 1'b1;
         endcase
      end
   end

   // Word packing and immediate range checks
   always_comb begin
      o_word      = 32'd0;
      o_range_err = 1'b0;
      case (w_fmt)
         FMT_R: o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_opc};
         FMT_I: begin
            o_word      = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
            o_range_err = ~w_fit12;
         end
         FMT_SH: begin
            o_word      = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, w_opc};
            o_range_err = |i_imm[31:5];
         end
         FMT_S: begin
            o_word      = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opc};
            o_range_err = ~w_fit12;
         end
         FMT_B: begin
            o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                           i_imm[4:1], i_imm[11], w_opc};
            o_range_err = i_imm[0] | ~w_fit13;
         end
         FMT_U: begin
            o_word      = {i_imm[31:12], i_rd, w_opc};
            o_range_err = |i_imm[11:0];
         end
         FMT_J: begin
            o_word      = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                           i_rd, w_opc};
            o_range_err = i_imm[0] | ~w_fit21;
         end
         default: o_word = 32'd0;
      endcase
      // An illegal combination has no meaningful immediate layout
      if (w_illegal) begin
         o_range_err = 1'b0;
      end
   end

   assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streaming RV32IM instruction encoder. Accepts decoded
//                micro-op fields over valid/ready, encodes them through a
//                two-stage pipeline (S1 capture, S2 encode/check/write) and
//                writes words to IMEM at consecutive addresses from
//                base_addr. Errors are sticky until the next start.
//                Optional feature macro: ENCODER_MEXT_EN (M-extension codes).
//  Ports       : clk, rst (async, active high), start, base_addr,
//                in_valid/in_ready, in_alucode, in_aluop1_type,
//                in_aluop2_type, in_rs1, in_rs2, in_rd, in_imm, in_last,
//                imem_we, imem_addr, imem_wdata, busy, done, err, err_code,
//                count
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_alucode,
   input  logic [1:0]        in_aluop1_type,
   input  logic [1:0]        in_aluop2_type,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   count
);
   import instr_encoder_pkg::*;

   localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

   state_t            r_state;
   // Stage 1: captured fields
   logic              r_s1_valid;
   logic              r_s1_last;
   logic [5:0]        r_s1_alucode;
   logic [1:0]        r_s1_op1;
   logic [1:0]        r_s1_op2;
   logic [4:0]        r_s1_rs1;
   logic [4:0]        r_s1_rs2;
   logic [4:0]        r_s1_rd;
   logic [31:0]       r_s1_imm;
   // Stage 2: IMEM write port and status
   logic              r_we;
   logic              r_we_last;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_done;
   logic              r_err;
   err_code_t         r_err_code;
   logic [ADDR_W:0]   r_count;
   // Next write address with a carry bit; carry set means the space is used up
   logic [ADDR_W:0]   r_ptr;

   logic              w_in_ready;
   logic              w_accept;
   logic [31:0]       w_enc_word;
   logic              w_enc_illegal;
   logic              w_enc_range;
   logic              w_ovf;
   logic              w_s2_err;
   logic              w_s2_write;
   err_code_t         w_s2_code;

   rv_encode_word u_encode (
      .i_alucode   (r_s1_alucode),
      .i_op1_type  (r_s1_op1),
      .i_op2_type  (r_s1_op2),
      .i_rs1       (r_s1_rs1),
      .i_rs2       (r_s1_rs2),
      .i_rd        (r_s1_rd),
      .i_imm       (r_s1_imm),
      .o_word      (w_enc_word),
      .o_illegal   (w_enc_illegal),
      .o_range_err (w_enc_range)
   );

   assign w_in_ready = (r_state == ST_RUN) && !r_err;
   assign w_accept   = in_valid && w_in_ready;
   assign w_ovf      = r_ptr[ADDR_W];
   assign w_s2_err   = r_s1_valid && (w_enc_illegal || w_enc_range || w_ovf);
   assign w_s2_write = r_s1_valid && !(w_enc_illegal || w_enc_range || w_ovf);

   always_comb begin
      w_s2_code = ERR_OVERFLOW;
      if (w_enc_illegal) begin
         w_s2_code = ERR_ILLEGAL;
      end else if (w_enc_range) begin
         w_s2_code = ERR_RANGE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_s1_valid   <= 1'b0;
         r_s1_last    <= 1'b0;
         r_s1_alucode <= 6'd0;
         r_s1_op1     <= 2'd0;
         r_s1_op2     <= 2'd0;
         r_s1_rs1     <= 5'd0;
         r_s1_rs2     <= 5'd0;
         r_s1_rd      <= 5'd0;
         r_s1_imm     <= 32'd0;
         r_we         <= 1'b0;
         r_we_last    <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_count      <= '0;
         r_ptr        <= '0;
      end else begin
         r_we      <= 1'b0;
         r_we_last <= 1'b0;
         r_done    <= 1'b0;

         // S1 refills every cycle; it never holds a word for more than one
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_last    <= in_last;
            r_s1_alucode <= in_alucode;
            r_s1_op1     <= in_aluop1_type;
            r_s1_op2     <= in_aluop2_type;
            r_s1_rs1     <= in_rs1;
            r_s1_rs2     <= in_rs2;
            r_s1_rd      <= in_rd;
            r_s1_imm     <= in_imm;
         end

         if (w_s2_write) begin
            r_we      <= 1'b1;
            r_we_last <= r_s1_last;
            r_addr    <= r_ptr[ADDR_W-1:0];
            r_wdata   <= w_enc_word;
            r_ptr     <= r_ptr + c_one;
            r_count   <= r_count + c_one;
         end

         case (r_state)
            ST_IDLE, ST_ERR: begin
               if (start) begin
                  r_state    <= ST_RUN;
                  r_ptr      <= {1'b0, base_addr};
                  r_count    <= '0;
                  r_err      <= 1'b0;
                  r_err_code <= ERR_NONE;
               end
            end
            ST_RUN: begin
               if (w_s2_err) begin
                  r_state <= ST_ERR;
               end else if (w_accept && in_last) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_s2_err) begin
                  r_state <= ST_ERR;
               end else if (r_we_last) begin
                  // Last word strobed in the previous cycle: pipeline empty
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // A failing word also flushes whatever was accepted behind it
         if (w_s2_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_s2_code;
            r_s1_valid <= 1'b0;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign busy       = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign done       = r_done;
   assign err        = r_err;
   assign err_code   = r_err_code;
   assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder. Instance A
//                uses the default 12-bit address, instance B a 4-bit address
//                for the end-of-memory case. Inputs other than start and
//                base_addr are shared; only the started instance reacts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic        clk;
   logic        rst;
   logic        start_a;
   logic        start_b;
   logic [11:0] base_a;
   logic [3:0]  base_b;
   logic        in_valid;
   logic [5:0]  in_alucode;
   logic [1:0]  in_op1;
   logic [1:0]  in_op2;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic [31:0] in_imm;
   logic        in_last;

   logic        a_ready, a_we, a_busy, a_done, a_err;
   logic [11:0] a_addr;
   logic [31:0] a_wdata;
   logic [1:0]  a_code;
   logic [12:0] a_count;

   logic        b_ready, b_we, b_busy, b_done, b_err;
   logic [3:0]  b_addr;
   logic [31:0] b_wdata;
   logic [1:0]  b_code;
   logic [4:0]  b_count;

   int checks;
   int errors;

   instr_encoder #(.ADDR_W(12)) u_dut_a (
      .clk            (clk),
      .rst            (rst),
      .start          (start_a),
      .base_addr      (base_a),
      .in_valid       (in_valid),
      .in_ready       (a_ready),
      .in_alucode     (in_alucode),
      .in_aluop1_type (in_op1),
      .in_aluop2_type (in_op2),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_rd          (in_rd),
      .in_imm         (in_imm),
      .in_last        (in_last),
      .imem_we        (a_we),
      .imem_addr      (a_addr),
      .imem_wdata     (a_wdata),
      .busy           (a_busy),
      .done           (a_done),
      .err            (a_err),
      .err_code       (a_code),
      .count          (a_count)
   );

   instr_encoder #(.ADDR_W(4)) u_dut_b (
      .clk            (clk),
      .rst            (rst),
      .start          (start_b),
      .base_addr      (base_b),
      .in_valid       (in_valid),
      .in_ready       (b_ready),
      .in_alucode     (in_alucode),
      .in_aluop1_type (in_op1),
      .in_aluop2_type (in_op2),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_rd          (in_rd),
      .in_imm         (in_imm),
      .in_last        (in_last),
      .imem_we        (b_we),
      .imem_addr      (b_addr),
      .imem_wdata     (b_wdata),
      .busy           (b_busy),
      .done           (b_done),
      .err            (b_err),
      .err_code       (b_code),
      .count          (b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [5:0] alu, input logic [1:0] t1, input logic [1:0] t2,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic last);
      in_valid   = 1'b1;
      in_alucode = alu;
      in_op1     = t1;
      in_op2     = t2;
      in_rs1     = rs1;
      in_rs2     = rs2;
      in_rd      = rd;
      in_imm     = imm;
      in_last    = last;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic go_a(input logic [11:0] base);
      start_a = 1'b1;
      base_a  = base;
      tick();
      start_a = 1'b0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      base_a     = 12'd0;
      base_b     = 4'd0;
      in_valid   = 1'b0;
      in_alucode = 6'd0;
      in_op1     = 2'd0;
      in_op2     = 2'd0;
      in_rs1     = 5'd0;
      in_rs2     = 5'd0;
      in_rd      = 5'd0;
      in_imm     = 32'd0;
      in_last    = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_we",    32'(a_we),    32'd0);
      chk("rst_addr",  32'(a_addr),  32'd0);
      chk("rst_wdata", a_wdata,      32'd0);
      chk("rst_ready", 32'(a_ready), 32'd0);
      chk("rst_busy",  32'(a_busy),  32'd0);
      chk("rst_done",  32'(a_done),  32'd0);
      chk("rst_err",   32'(a_err),   32'd0);
      chk("rst_code",  32'(a_code),  32'd0);
      chk("rst_count", 32'(a_count), 32'd0);
      rst = 1'b0;
      tick();

      // ADDI x1,x0,5 as a one-word program
      go_a(12'h010);
      chk("t1_busy",  32'(a_busy),  32'd1);
      chk("t1_ready", 32'(a_ready), 32'd1);
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd5, 1'b1);
      tick();
      idle_in();
      chk("t1_we_lat", 32'(a_we), 32'd0);
      tick();
      chk("t1_we",    32'(a_we),    32'd1);
      chk("t1_addr",  32'(a_addr),  32'h010);
      chk("t1_wdata", a_wdata,      32'h00500093);
      chk("t1_count", 32'(a_count), 32'd1);
      chk("t1_ndone", 32'(a_done),  32'd0);
      tick();
      chk("t1_done",  32'(a_done),  32'd1);
      chk("t1_we0",   32'(a_we),    32'd0);
      chk("t1_idle",  32'(a_busy),  32'd0);
      tick();
      chk("t1_done0", 32'(a_done),  32'd0);

      // Back-to-back SUB then LUI
      go_a(12'h020);
      send(ALU_SUB, OP_TYPE_REG, OP_TYPE_REG, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
      tick();
      send(ALU_LUI, OP_TYPE_IMM, OP_TYPE_NONE, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1);
      tick();
      idle_in();
      chk("t2_we0",    32'(a_we),   32'd1);
      chk("t2_addr0",  32'(a_addr), 32'h020);
      chk("t2_data0",  a_wdata,     32'h402081B3);
      tick();
      chk("t2_we1",    32'(a_we),    32'd1);
      chk("t2_addr1",  32'(a_addr),  32'h021);
      chk("t2_data1",  a_wdata,      32'h123452B7);
      chk("t2_count",  32'(a_count), 32'd2);
      tick();
      chk("t2_done",   32'(a_done),  32'd1);
      tick();

      // SRAI / SW / JAL stream with edge-of-range immediates
      go_a(12'h060);
      send(ALU_SRA, OP_TYPE_REG, OP_TYPE_IMM, 5'd4, 5'd0, 5'd4, 32'd31, 1'b0);
      tick();
      send(ALU_SW, OP_TYPE_REG, OP_TYPE_IMM, 5'd2, 5'd5, 5'd0, 32'hFFFFF800, 1'b0);
      tick();
      chk("t3_srai",   a_wdata,      32'h41F25213);
      chk("t3_addr0",  32'(a_addr),  32'h060);
      send(ALU_JAL, OP_TYPE_PC, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b1);
      tick();
      idle_in();
      chk("t3_sw",     a_wdata,      32'h80512023);
      chk("t3_addr1",  32'(a_addr),  32'h061);
      tick();
      chk("t3_jal",    a_wdata,      32'h001000EF);
      chk("t3_addr2",  32'(a_addr),  32'h062);
      chk("t3_count",  32'(a_count), 32'd3);
      tick();
      chk("t3_done",   32'(a_done),  32'd1);
      tick();

      // Misaligned branch: RANGE; the word queued behind it is discarded
      go_a(12'h040);
      send(ALU_BEQ, OP_TYPE_REG, OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'd3, 1'b0);
      tick();
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd7, 1'b1);
      tick();
      idle_in();
      chk("t4_we",    32'(a_we),    32'd0);
      chk("t4_err",   32'(a_err),   32'd1);
      chk("t4_code",  32'(a_code),  32'd2);
      chk("t4_ready", 32'(a_ready), 32'd0);
      tick();
      chk("t4_flush", 32'(a_we),    32'd0);
      chk("t4_ndone", 32'(a_done),  32'd0);
      chk("t4_sticky",32'(a_err),   32'd1);

      // Restart from ERR; BNE with a negative offset
      go_a(12'h050);
      chk("t4_clr_err",  32'(a_err),   32'd0);
      chk("t4_clr_code", 32'(a_code),  32'd0);
      chk("t4_rdy",      32'(a_ready), 32'd1);
      send(ALU_BNE, OP_TYPE_REG, OP_TYPE_REG, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b1);
      tick();
      idle_in();
      tick();
      chk("t4_bne_we",   32'(a_we),   32'd1);
      chk("t4_bne_addr", 32'(a_addr), 32'h050);
      chk("t4_bne",      a_wdata,     32'hFE209CE3);
      tick();
      chk("t4_bne_done", 32'(a_done), 32'd1);
      tick();

      // I-type boundary: 2047 is written, 2048 is RANGE
      go_a(12'h080);
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd2047, 1'b0);
      tick();
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b1);
      tick();
      idle_in();
      chk("t5_we",    32'(a_we),  32'd1);
      chk("t5_2047",  a_wdata,    32'h7FF00093);
      tick();
      chk("t5_we0",   32'(a_we),    32'd0);
      chk("t5_err",   32'(a_err),   32'd1);
      chk("t5_code",  32'(a_code),  32'd2);
      chk("t5_count", 32'(a_count), 32'd1);

      // SUB with an immediate operand has no encoding: ILLEGAL
      go_a(12'h090);
      chk("t6_count0", 32'(a_count), 32'd0);
      send(ALU_SUB, OP_TYPE_REG, OP_TYPE_IMM, 5'd1, 5'd0, 5'd2, 32'd4, 1'b1);
      tick();
      idle_in();
      tick();
      chk("t6_we",   32'(a_we),   32'd0);
      chk("t6_err",  32'(a_err),  32'd1);
      chk("t6_code", 32'(a_code), 32'd1);

      // MUL x1,x2,x3
      go_a(12'h070);
      send(ALU_MUL, OP_TYPE_REG, OP_TYPE_REG, 5'd2, 5'd3, 5'd1, 32'd0, 1'b1);
      tick();
      idle_in();
      tick();
`ifdef ENCODER_MEXT_EN
      chk("t7_we",   32'(a_we),   32'd1);
      chk("t7_addr", 32'(a_addr), 32'h070);
      chk("t7_mul",  a_wdata,     32'h023100B3);
      tick();
      chk("t7_done", 32'(a_done), 32'd1);
`else
      chk("t7_we",   32'(a_we),   32'd0);
      chk("t7_err",  32'(a_err),  32'd1);
      chk("t7_code", 32'(a_code), 32'd1);
      tick();
`endif
      tick();

      // 4-bit address space: 0xE, 0xF written, third word overflows
      start_b = 1'b1;
      base_b  = 4'hE;
      tick();
      start_b = 1'b0;
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0);
      tick();
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd2, 1'b0);
      tick();
      chk("t8_we0",   32'(b_we),   32'd1);
      chk("t8_addr0", 32'(b_addr), 32'hE);
      chk("t8_data0", b_wdata,     32'h00100093);
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd3, 1'b1);
      tick();
      idle_in();
      chk("t8_we1",   32'(b_we),    32'd1);
      chk("t8_addr1", 32'(b_addr),  32'hF);
      chk("t8_cnt1",  32'(b_count), 32'd2);
      tick();
      chk("t8_we2",   32'(b_we),    32'd0);
      chk("t8_err",   32'(b_err),   32'd1);
      chk("t8_code",  32'(b_code),  32'd3);
      chk("t8_cnt2",  32'(b_count), 32'd2);
      chk("t8_a_idle",32'(a_we),    32'd0);
      tick();

      // Reset while draining with two words in flight
      go_a(12'h0A0);
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd1, 32'd1, 1'b0);
      tick();
      send(ALU_ADD, OP_TYPE_REG, OP_TYPE_IMM, 5'd0, 5'd0, 5'd2, 32'd2, 1'b1);
      tick();
      idle_in();
      chk("t9_pre_we", 32'(a_we), 32'd1);
      rst = 1'b1;
      tick();
      chk("t9_we",    32'(a_we),    32'd0);
      chk("t9_addr",  32'(a_addr),  32'd0);
      chk("t9_wdata", a_wdata,      32'd0);
      chk("t9_busy",  32'(a_busy),  32'd0);
      chk("t9_done",  32'(a_done),  32'd0);
      chk("t9_count", 32'(a_count), 32'd0);
      chk("t9_err",   32'(a_err),   32'd0);
      chk("t9_b_err", 32'(b_err),   32'd0);
      rst = 1'b0;
      tick();
      chk("t9_we_a",   32'(a_we),   32'd0);
      chk("t9_done_a", 32'(a_done), 32'd0);
      tick();
      chk("t9_we_b",   32'(a_we),   32'd0);
      chk("t9_done_b", 32'(a_done), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
